apb_arbiter_rr: RTL and testbench
=================================

# apb_arbiter_rr

Round-robin arbiter that shares the single downstream APB master port between `MASTER_PORTS` core-side APB masters. It sits between the cores and `apb_intercon_s`, whose S-side it drives with one master at a time. It sequences each granted request through its own SETUP/ACCESS phases and returns `PREADY`/`PRDATA` only to the granted core.

## Interface
- `BUS_WIDTH`, 16, address and data width.
- `MASTER_PORTS`, 2, number of requesting cores (≥2).
- `GW`, `$clog2(MASTER_PORTS)`, grant index width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `S_PADDR`  in  `MASTER_PORTS*BUS_WIDTH`  per-core address; core i occupies bits `[i*BUS_WIDTH +: BUS_WIDTH]`.
- `S_PWRITE`  in  `MASTER_PORTS`  per-core write flag.
- `S_PSELx`  in  `MASTER_PORTS`  per-core select; this is the request.
- `S_PENABLE`  in  `MASTER_PORTS`  per-core enable; ignored for arbitration.
- `S_PWDATA`  in  `MASTER_PORTS*BUS_WIDTH`  per-core write data.
- `S_PRDATA`  out  `MASTER_PORTS*BUS_WIDTH`  per-core read data.
- `S_PREADY`  out  `MASTER_PORTS`  per-core ready.
- `M_PADDR`  out  `BUS_WIDTH`  to interconnect.
- `M_PWRITE`  out  1  to interconnect.
- `M_PSELx`  out  1  to interconnect; slave decode stays in the interconnect.
- `M_PENABLE`  out  1  to interconnect.
- `M_PWDATA`  out  `BUS_WIDTH`  to interconnect.
- `M_PRDATA`  in  `BUS_WIDTH`  from interconnect.
- `M_PREADY`  in  1  from interconnect.
- `grant_id`  out  `GW`  index of the current or last granted core (debug/trace).

## Operation
- FSM states:
  - IDLE: no grant.
  - SETUP: `M_PSELx`=1, `M_PENABLE`=0.
  - ACCESS: `M_PSELx`=1, `M_PENABLE`=1.
- Request vector `req = S_PSELx`.
- Priority pointer `ptr` (GW bits) names the highest-priority core. Search order is `ptr, ptr+1, …, MASTER_PORTS-1, 0, …, ptr-1`; the first core with `req` set wins.
- IDLE with any `req` set: register the winner into `grant`, then go to SETUP. IDLE with no request: stay in IDLE.
- SETUP: go to ACCESS unconditionally after 1 cycle.
- ACCESS with `M_PREADY`=1: transfer completes. Set `ptr <= (grant+1) mod MASTER_PORTS`, then go to IDLE.
- ACCESS with `M_PREADY`=0: hold ACCESS (wait states, unbounded).
- In SETUP/ACCESS, `M_PADDR`, `M_PWRITE` and `M_PWDATA` are combinational muxes of the granted core's lanes. Cores obey APB and hold these stable until their `PREADY`.
- In IDLE, `M_PADDR`, `M_PWDATA`, `M_PWRITE`, `M_PSELx` and `M_PENABLE` are all 0.
- `S_PREADY[i] = (state==ACCESS) & (grant==i) & M_PREADY`. All other cores see 0 and therefore stall.
- `S_PRDATA` lane i carries `M_PRDATA` when `S_PREADY[i]`, and 0 otherwise.
- Grant is locked for the whole transfer:
  - A core dropping `S_PSELx` after grant (protocol violation) does not abort it; the transfer runs to `M_PREADY`.
  - New requests arriving during SETUP/ACCESS wait for IDLE.
- The mandatory IDLE cycle after every transfer lets the finished core deassert `S_PSELx` before the next arbitration. The same core can never be re-granted while its old request is still visible.
- Pointer wrap: `grant = MASTER_PORTS-1` sets `ptr` to 0.

## Timing
- Reset (async assert, sync deassert by the system) forces:
  - state = IDLE, `grant` = 0, `ptr` = 0, `grant_id` = 0.
  - All M_* outputs = 0; all `S_PREADY` and `S_PRDATA` = 0.
- Reset mid-SETUP/ACCESS abandons the transfer immediately. No `S_PREADY` pulse is issued for it.
- Request sampled in IDLE at cycle T:
  - SETUP at T+1.
  - ACCESS at T+2.
  - `S_PREADY` at T+2 for a zero-wait slave; each wait state adds 1 cycle.
  - IDLE at the cycle after `M_PREADY`.
- Maximum throughput is 1 transfer per 3 cycles.
- `S_PREADY` and `S_PRDATA` are combinational from `M_PREADY` and `M_PRDATA`, so there is no added latency on the return path.
- With N cores continuously requesting, each waits at most `(N-1)` transfers between grants.

## Test plan
- Single read:
  - Stimulus: core0 requests `PADDR=0x0088`, slave returns `0x1234` with 0 waits.
  - Required: SETUP at T+1, ACCESS at T+2, `S_PREADY[0]`=1 and `S_PRDATA[0]=0x1234` at T+2, `S_PREADY[1]`=0 throughout.
- Simultaneous requests:
  - Stimulus: after reset, core0 and core1 both assert at the same cycle.
  - Required: core0 is granted first; core1 gets SETUP 1 idle cycle after core0 completes; `grant_id` sequence is 0,1.
- Fairness:
  - Stimulus: `MASTER_PORTS=4`, all cores requesting continuously for 8 transfers.
  - Required: grant order 0,1,2,3,0,1,2,3.
- Sparse requests:
  - Stimulus: `MASTER_PORTS=4`, `ptr`=3, only cores 1 and 2 request.
  - Required: core1 is granted, then core2.
- Wait states:
  - Stimulus: core1 writes `0xBEEF` to `0x00C4`; slave holds `M_PREADY` low 3 cycles.
  - Required: ACCESS held 4 cycles with `M_PWDATA=0xBEEF` and `M_PADDR=0x00C4` stable; `S_PREADY[1]` only in the last cycle.
- Reset mid-ACCESS:
  - Stimulus: assert `reset`=0 during a wait state.
  - Required: all outputs 0 in the same cycle, state IDLE, `ptr`=0; the next request from core0 is granted normally.

Source files
------------

// File: rtl/apb_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_arbiter_rr_if
// Brief    : Core-side and interconnect-side APB lanes of the round-robin
//            arbiter. The arbiter takes the slave view; the environment
//            (cores plus interconnect) takes the master view.
// Revision : 1.0
// ============================================================================
interface apb_arbiter_rr_if #(
    parameter int BUS_WIDTH    = 16,
    parameter int MASTER_PORTS = 2
);
    // Per-core lanes, core i at [i*BUS_WIDTH +: BUS_WIDTH]
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
    logic [MASTER_PORTS-1:0]           S_PWRITE;
    logic [MASTER_PORTS-1:0]           S_PSELx;
    logic [MASTER_PORTS-1:0]           S_PENABLE;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
    logic [MASTER_PORTS-1:0]           S_PREADY;

    // Shared downstream port towards the interconnect
    logic [BUS_WIDTH-1:0]              M_PADDR;
    logic                              M_PWRITE;
    logic                              M_PSELx;
    logic                              M_PENABLE;
    logic [BUS_WIDTH-1:0]              M_PWDATA;
    logic [BUS_WIDTH-1:0]              M_PRDATA;
    logic                              M_PREADY;

    modport slave (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        input  M_PRDATA, M_PREADY,
        output S_PRDATA, S_PREADY,
        output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );

    modport master (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        output M_PRDATA, M_PREADY,
        input  S_PRDATA, S_PREADY,
        input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : apb_arbiter_rr
// Brief    : Round-robin arbiter sharing one downstream APB port between
//            MASTER_PORTS cores; each grant runs a full SETUP/ACCESS transfer.
// Revision : 1.0
// ============================================================================
module apb_arbiter_rr #(
    parameter int BUS_WIDTH    = 16,
    parameter int MASTER_PORTS = 2,
    parameter int GW           = $clog2(MASTER_PORTS)
) (
    input  logic           clk,
    input  logic           reset,
    apb_arbiter_rr_if.slave bus,
    output logic [GW-1:0]  grant_id
);

    localparam logic [GW-1:0] c_LAST_CORE = GW'(MASTER_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [GW-1:0]               r_grant;
    logic [GW-1:0]               w_grant_nxt;
    logic [GW-1:0]               r_ptr;
    logic [GW-1:0]               w_ptr_nxt;

    logic                        w_found;
    logic [GW-1:0]               w_winner;
    int                          w_best;
    int                          w_dist;

    logic [BUS_WIDTH-1:0]        w_m_paddr;
    logic [BUS_WIDTH-1:0]        w_m_pwdata;
    logic                        w_m_pwrite;
    logic [MASTER_PORTS-1:0]     w_s_pready;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] w_s_prdata;

    // PENABLE from the cores carries no arbitration meaning
    logic                        w_unused_penable;
    assign w_unused_penable = ^bus.S_PENABLE;

    // Winner is the requester closest to ptr in rotation order
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = MASTER_PORTS;
        w_dist   = 0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            w_dist = (i + MASTER_PORTS - int'(r_ptr)) % MASTER_PORTS;
            if (bus.S_PSELx[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_found  = 1'b1;
                w_winner = GW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.M_PREADY) begin
                    w_ptr_nxt   = (r_grant == c_LAST_CORE) ? '0 : r_grant + GW'(1);
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Lane steering; the return path is purely combinational from M_PREADY/M_PRDATA
    always_comb begin
        w_m_paddr  = '0;
        w_m_pwdata = '0;
        w_m_pwrite = 1'b0;
        w_s_pready = '0;
        w_s_prdata = '0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if ((r_state != ST_IDLE) && (r_grant == GW'(i))) begin
                w_m_paddr  = bus.S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
                w_m_pwdata = bus.S_PWDATA[i*BUS_WIDTH +: BUS_WIDTH];
                w_m_pwrite = bus.S_PWRITE[i];
                if ((r_state == ST_ACCESS) && bus.M_PREADY) begin
                    w_s_pready[i]                           = 1'b1;
                    w_s_prdata[i*BUS_WIDTH +: BUS_WIDTH]    = bus.M_PRDATA;
                end
            end
        end
    end

    assign bus.M_PSELx   = (r_state != ST_IDLE);
    assign bus.M_PENABLE = (r_state == ST_ACCESS);
    assign bus.M_PADDR   = w_m_paddr;
    assign bus.M_PWDATA  = w_m_pwdata;
    assign bus.M_PWRITE  = w_m_pwrite;
    assign bus.S_PREADY  = w_s_pready;
    assign bus.S_PRDATA  = w_s_prdata;
    assign grant_id      = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_arbiter_rr
// Brief    : Directed and randomized bench for apb_arbiter_rr with a
//            transfer-level reference model of the arbitration rules.
// Revision : 1.0
// ============================================================================
module tb_apb_arbiter_rr;

    localparam int BW   = 16;
    localparam int NP   = 4;
    localparam int GWID = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [GWID-1:0] grant_id;

    apb_arbiter_rr_if #(.BUS_WIDTH(BW), .MASTER_PORTS(NP)) bus ();

    apb_arbiter_rr #(.BUS_WIDTH(BW), .MASTER_PORTS(NP), .GW(GWID)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    // Stimulus state for cores and the downstream slave
    logic [NP-1:0] c_req;
    logic [NP-1:0] c_write;
    logic [BW-1:0] c_addr  [NP];
    logic [BW-1:0] c_wdata [NP];
    logic          sl_ready;
    logic [BW-1:0] sl_rdata;

    // Reference model: one transfer in flight, age counts cycles since grant
    bit            m_busy;
    int            m_owner;
    int            m_age;
    int            m_ptr;
    int            m_last;
    logic [NP-1:0] done;
    int            gseq[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            bus.S_PADDR[i*BW +: BW]  = c_addr[i];
            bus.S_PWDATA[i*BW +: BW] = c_wdata[i];
        end
        bus.S_PSELx   = c_req;
        bus.S_PENABLE = c_req;
        bus.S_PWRITE  = c_write;
        bus.M_PREADY  = sl_ready;
        bus.M_PRDATA  = sl_rdata;
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_age   = 0;
        m_ptr   = 0;
        m_last  = 0;
        done    = '0;
    endtask

    task automatic model_advance();
        bit found;
        found = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < NP; k++) begin
                if (!found && c_req[(m_ptr + k) % NP]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = (m_ptr + k) % NP;
                    m_age   = 0;
                    m_last  = m_owner;
                end
            end
        end else if (m_age >= 1 && sl_ready) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NP;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_outputs();
        logic [BW-1:0]    e_addr;
        logic [BW-1:0]    e_wdata;
        logic             e_write;
        logic             e_acc;
        logic [NP-1:0]    e_rdy;
        logic [NP*BW-1:0] e_rdata;
        e_acc   = m_busy && (m_age >= 1);
        e_addr  = '0;
        e_wdata = '0;
        e_write = 1'b0;
        e_rdy   = '0;
        e_rdata = '0;
        if (m_busy) begin
            e_addr  = c_addr[m_owner];
            e_wdata = c_wdata[m_owner];
            e_write = c_write[m_owner];
        end
        if (e_acc && sl_ready) begin
            e_rdy[m_owner]            = 1'b1;
            e_rdata[m_owner*BW +: BW] = sl_rdata;
        end
        check("m_psel",    bus.M_PSELx,   m_busy);
        check("m_penable", bus.M_PENABLE, e_acc);
        check("m_paddr",   bus.M_PADDR,   e_addr);
        check("m_pwdata",  bus.M_PWDATA,  e_wdata);
        check("m_pwrite",  bus.M_PWRITE,  e_write);
        check("s_pready",  bus.S_PREADY,  e_rdy);
        check("s_prdata",  bus.S_PRDATA,  e_rdata);
        check("grant_id",  grant_id,      m_last);
        done = e_rdy;
        if (bus.M_PSELx && !bus.M_PENABLE) gseq.push_back(int'(grant_id));
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, return at edge+1
    task automatic tick();
        drive();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((c_req != '0 || m_busy) && n < budget) begin
            tick();
            for (int i = 0; i < NP; i++) if (done[i]) c_req[i] = 1'b0;
            n++;
        end
        if (c_req != '0 || m_busy) check("drain_timeout", {63'd0, m_busy}, 64'd0);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        c_req = '0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic random_policy();
        for (int i = 0; i < NP; i++) begin
            if (done[i]) c_req[i] = 1'b0;
            if (!c_req[i] && ($urandom_range(0, 3) == 0)) begin
                c_req[i]   = 1'b1;
                c_addr[i]  = BW'($urandom);
                c_wdata[i] = BW'($urandom);
                c_write[i] = 1'($urandom_range(0, 1));
            end
        end
        sl_ready = ($urandom_range(0, 2) != 0);
        sl_rdata = BW'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        c_req    = '0;
        c_write  = '0;
        sl_ready = 1'b0;
        sl_rdata = '0;
        for (int i = 0; i < NP; i++) begin
            c_addr[i]  = '0;
            c_wdata[i] = '0;
        end
        model_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        reset_dut();
        check("rst_grant_id", grant_id, 0);

        // Single read from core0
        c_req[0] = 1'b1; c_addr[0] = 16'h0088; c_write[0] = 1'b0;
        sl_ready = 1'b1; sl_rdata = 16'h1234;
        tick();
        check("rd_setup_psel", bus.M_PSELx, 1);
        check("rd_setup_pen",  bus.M_PENABLE, 0);
        tick();
        check("rd_acc_pen",    bus.M_PENABLE, 1);
        check("rd_pready",     bus.S_PREADY, 4'b0001);
        check("rd_prdata",     bus.S_PRDATA[15:0], 16'h1234);
        c_req[0] = 1'b0;
        tick();
        check("rd_idle_psel",  bus.M_PSELx, 0);

        // Simultaneous requests after reset
        reset_dut();
        gseq.delete();
        c_req[0] = 1'b1; c_req[1] = 1'b1;
        c_addr[1] = 16'h0010; c_wdata[1] = 16'h5555; c_write[1] = 1'b1;
        drain(40);
        check("simul_n", gseq.size(), 2);
        for (int k = 0; k < 2 && k < gseq.size(); k++) check("simul_order", gseq[k], k);

        // Fairness with all cores requesting
        reset_dut();
        gseq.delete();
        c_req = '1;
        for (int n = 0; n < 200 && gseq.size() < 8; n++) begin
            tick();
            for (int i = 0; i < NP; i++) begin
                if (done[i]) begin
                    if (gseq.size() >= 8) c_req[i] = 1'b0;
                    else c_addr[i] = BW'($urandom);
                end
            end
        end
        drain(100);
        check("fair_n", gseq.size() >= 8, 1);
        for (int k = 0; k < 8 && k < gseq.size(); k++) check("fair_order", gseq[k], k % NP);

        // Sparse requests with ptr=3 (left there by a core2 transfer)
        reset_dut();
        c_req[2] = 1'b1;
        drain(20);
        gseq.delete();
        c_req[1] = 1'b1; c_req[2] = 1'b1;
        drain(40);
        check("sparse_n", gseq.size(), 2);
        for (int k = 0; k < 2 && k < gseq.size(); k++) check("sparse_order", gseq[k], k + 1);

        // Wait states on a core1 write
        sl_ready = 1'b0;
        c_req[1] = 1'b1; c_addr[1] = 16'h00C4; c_wdata[1] = 16'hBEEF; c_write[1] = 1'b1;
        tick();
        tick();
        for (int w = 0; w < 4; w++) begin
            sl_ready = (w == 3);
            drive();
            #1;
            check("ws_pen",    bus.M_PENABLE, 1);
            check("ws_paddr",  bus.M_PADDR, 16'h00C4);
            check("ws_pwdata", bus.M_PWDATA, 16'hBEEF);
            check("ws_pready", bus.S_PREADY, (w == 3) ? 4'b0010 : 4'b0000);
            if (w == 3) c_req[1] = 1'b0;
            tick();
        end
        check("ws_idle_psel", bus.M_PSELx, 0);

        // Reset while core3 sits in ACCESS
        sl_ready = 1'b0;
        c_req[3] = 1'b1; c_addr[3] = 16'h0F00; c_write[3] = 1'b0;
        tick();
        tick();
        sl_ready = 1'b1; sl_rdata = 16'hCAFE;
        drive();
        reset = 1'b0;
        #1;
        check("rst_psel",   bus.M_PSELx, 0);
        check("rst_pen",    bus.M_PENABLE, 0);
        check("rst_paddr",  bus.M_PADDR, 0);
        check("rst_pready", bus.S_PREADY, 0);
        check("rst_prdata", bus.S_PRDATA, 0);
        check("rst_gid",    grant_id, 0);
        model_reset();
        c_req = '0;
        tick();
        reset = 1'b1;
        tick();
        gseq.delete();
        c_req[0] = 1'b1; c_req[3] = 1'b1;
        drain(40);
        check("postrst_n", gseq.size(), 2);
        if (gseq.size() == 2) begin
            check("postrst_first",  gseq[0], 0);
            check("postrst_second", gseq[1], 3);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            random_policy();
            tick();
        end
        sl_ready = 1'b1;
        drain(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
